pll_reset_sequencer: RTL and testbench



---
 rtl/pll_reset_sequencer.sv | 127 ++++++++++++
 tb/tb_pll_reset_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses pll_rst, waits for
// synchronized lock with timeout-and-retry, qualifies lock, then releases the core reset.
module pll_reset_sequencer #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 65536,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             reset_req,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam logic [1:0] S_RESET_PLL = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  // Wide enough for the largest timeout/qualification parameter.
  localparam int unsigned CW = 24;

  localparam logic [CW-1:0]    RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0]    TO_LAST     = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;
  localparam logic [CW-1:0]    CW_SAT      = '1;

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nx;
  logic             restart;
  logic [CNT_W-1:0] retry_nx;
  logic [CNT_W-1:0] loss_nx;
  logic [1:0]       sync_q;
  logic             lk;

  assign lk      = sync_q[1];
  assign state_o = state;

  // Lock synchronizer; held clear while the PLL is in reset so lock is re-acquired from scratch.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else if (state == S_RESET_PLL) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  // Next-state, counter and event-counter logic.
  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    retry_nx = retry_cnt;
    loss_nx  = loss_cnt;
    cnt_nx   = cnt;
    case (state)
      S_RESET_PLL: begin
        if (cnt == RST_LAST) state_nx = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lk) begin
          state_nx = S_STABLE;
        end else if (cnt == TO_LAST) begin
          state_nx = S_RESET_PLL;
          if (retry_cnt != CNT_SAT) retry_nx = retry_cnt + CNT_W'(1);
        end
      end
      S_STABLE: begin
        if (!lk) begin
          state_nx = S_WAIT_LOCK;
        end else if (reset_req) begin
          restart = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (!lk) begin
          state_nx = S_RESET_PLL;
          if (loss_cnt != CNT_SAT) loss_nx = loss_cnt + CNT_W'(1);
        end else if (reset_req) begin
          state_nx = S_STABLE;
        end
      end
      default: state_nx = S_RESET_PLL;
    endcase

    // Shared counter restarts on any state change; it parks at all-ones rather than wrapping.
    if ((state_nx != state) || restart) begin
      cnt_nx = '0;
    end else if (cnt != CW_SAT) begin
      cnt_nx = cnt + CW'(1);
    end
  end

  // State, counters and decoded outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
      sys_reset <= 1'b1;
      ready     <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry_cnt <= retry_nx;
      loss_cnt  <= loss_nx;
      pll_rst   <= (state_nx == S_RESET_PLL);
      sys_reset <= (state_nx != S_RUN);
      ready     <= (state_nx == S_RUN);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scenario bench for pll_reset_sequencer: expected timelines and counter values are
// queued as stimulus is applied and popped as the DUT responds.
module tb_pll_reset_sequencer;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 20;
  localparam int unsigned STABLE_CYCLES = 8;
  localparam int unsigned CNT_W         = 2;
  localparam int          RETRY_PERIOD  = RST_CYCLES + LOCK_TIMEOUT;
  localparam int          START_LAT     = RST_CYCLES + 2 + STABLE_CYCLES + 1;

  logic             refclk = 1'b0;
  logic             rst_n;
  logic             pll_locked;
  logic             reset_req;
  logic             pll_rst;
  logic             sys_reset;
  logic             ready;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] retry_cnt;
  logic [CNT_W-1:0] loss_cnt;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  pll_reset_sequencer #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .reset_req (reset_req),
    .pll_rst   (pll_rst),
    .sys_reset (sys_reset),
    .ready     (ready),
    .state_o   (state_o),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt)
  );

  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic wait_state(input logic [1:0] s, input int budget, output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      tick();
      n++;
      if (state_o == s) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pll_locked = 1'b1; reset_req = 1'b0;
    tick(); tick();
    checks++;
    if ({pll_rst, sys_reset, ready, state_o, retry_cnt, loss_cnt} !== 9'b1_1_0_00_00_00) begin
      errors++;
      $display("FAIL reset_values: got %b want 110000000",
               {pll_rst, sys_reset, ready, state_o, retry_cnt, loss_cnt});
    end
  endtask

  task automatic test_startup();
    int rst_hi;
    int ready_k;
    logic [1:0] e;
    for (int k = 0; k <= START_LAT; k++) begin
      if (k < int'(RST_CYCLES)) exp_q.push_back(0);
      else if (k < int'(RST_CYCLES) + 3) exp_q.push_back(1);
      else if (k < START_LAT) exp_q.push_back(2);
      else exp_q.push_back(3);
    end
    rst_hi = 0; ready_k = -1;
    rst_n = 1'b1;
    for (int k = 0; k <= START_LAT; k++) begin
      if (k > 0) tick();
      e = 2'(exp_q.pop_front());
      checks++;
      if ({state_o, pll_rst, sys_reset, ready} !== {e, e == 2'd0, e != 2'd3, e == 2'd3}) begin
        errors++;
        $display("FAIL startup_k%0d: state/pll_rst/sys_reset/ready got %b want %b", k,
                 {state_o, pll_rst, sys_reset, ready}, {e, e == 2'd0, e != 2'd3, e == 2'd3});
      end
      if (pll_rst) rst_hi++;
      if (ready && ready_k < 0) ready_k = k;
    end
    checks++;
    if (rst_hi !== int'(RST_CYCLES)) begin
      errors++;
      $display("FAIL startup_pll_rst_width: got %0d want %0d", rst_hi, RST_CYCLES);
    end
    checks++;
    if (ready_k !== START_LAT) begin
      errors++;
      $display("FAIL startup_ready_latency: got %0d want %0d", ready_k, START_LAT);
    end
    checks++;
    if (retry_cnt !== 2'd0) begin
      errors++;
      $display("FAIL startup_retry: got %0d want 0", retry_cnt);
    end
  endtask

  task automatic test_retry();
    logic prev;
    int rises;
    int last_rise;
    rst_n = 1'b0; pll_locked = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(3);
    prev = pll_rst; rises = 0; last_rise = 0;
    for (int k = 1; k <= 5 * RETRY_PERIOD && rises < 4; k++) begin
      tick();
      if (pll_rst && !prev) begin
        rises++;
        checks++;
        if (retry_cnt !== 2'(exp_q[0])) begin
          errors++;
          $display("FAIL retry_cnt_%0d: got %0d want %0d", rises, retry_cnt, exp_q[0]);
        end
        void'(exp_q.pop_front());
        checks++;
        if (k - last_rise !== RETRY_PERIOD) begin
          errors++;
          $display("FAIL retry_period_%0d: got %0d want %0d", rises, k - last_rise, RETRY_PERIOD);
        end
        last_rise = k;
      end
      prev = pll_rst;
    end
    checks++;
    if (rises !== 4) begin
      errors++;
      $display("FAIL retry_timeout: saw %0d pll_rst pulses want 4", rises);
    end
    exp_q.delete();
  endtask

  task automatic test_stable_glitch();
    bit ok;
    logic [1:0] e;
    pll_locked = 1'b1;
    wait_state(2'd2, 100, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL glitch_reach_stable: state %0d want 2", state_o);
    end
    repeat (5) tick();
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) exp_q.push_back(1);
      else if (k == 12) exp_q.push_back(3);
      else exp_q.push_back(2);
    end
    pll_locked = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) pll_locked = 1'b1;
      e = 2'(exp_q.pop_front());
      checks++;
      if (state_o !== e) begin
        errors++;
        $display("FAIL glitch_state_k%0d: got %0d want %0d", k, state_o, e);
      end
    end
    checks++;
    if (loss_cnt !== 2'd0) begin
      errors++;
      $display("FAIL glitch_loss_cnt: got %0d want 0", loss_cnt);
    end
  endtask

  task automatic test_lock_loss();
    int first_k;
    int ready_k;
    first_k = -1; ready_k = -1;
    pll_locked = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (pll_rst && sys_reset && first_k < 0) first_k = k;
    end
    checks++;
    if (first_k !== 3) begin
      errors++;
      $display("FAIL loss_reaction: pll_rst&sys_reset at cycle %0d want 3", first_k);
    end
    checks++;
    if ({state_o, loss_cnt} !== {2'd0, 2'd1}) begin
      errors++;
      $display("FAIL loss_state_cnt: got state %0d loss %0d want state 0 loss 1", state_o, loss_cnt);
    end
    pll_locked = 1'b1;
    for (int k = 4; k <= 40 && ready_k < 0; k++) begin
      tick();
      if (ready) ready_k = k;
    end
    checks++;
    if (ready_k !== 3 + START_LAT) begin
      errors++;
      $display("FAIL loss_resequence_ready: got cycle %0d want %0d", ready_k, 3 + START_LAT);
    end
  endtask

  task automatic test_reset_req();
    int sr_hi;
    int pr_hi;
    int ready_k;
    bit ok;
    sr_hi = 0; pr_hi = 0; ready_k = -1;
    reset_req = 1'b1;
    for (int k = 1; k <= int'(STABLE_CYCLES) + 1; k++) begin
      tick();
      if (k == 1) reset_req = 1'b0;
      if (sys_reset) sr_hi++;
      if (pll_rst) pr_hi++;
      if (ready && ready_k < 0) ready_k = k;
    end
    checks++;
    if (pr_hi !== 0) begin
      errors++;
      $display("FAIL req_pll_rst: high for %0d cycles want 0", pr_hi);
    end
    checks++;
    if (sr_hi !== int'(STABLE_CYCLES)) begin
      errors++;
      $display("FAIL req_sys_reset_width: got %0d want %0d", sr_hi, STABLE_CYCLES);
    end
    checks++;
    if (ready_k !== int'(STABLE_CYCLES) + 1) begin
      errors++;
      $display("FAIL req_ready_cycle: got %0d want %0d", ready_k, STABLE_CYCLES + 1);
    end
    // Lock loss reaches the FSM in the same cycle as the request.
    pll_locked = 1'b0;
    tick(); tick();
    reset_req = 1'b1;
    tick();
    reset_req = 1'b0;
    checks++;
    if ({state_o, pll_rst, loss_cnt} !== {2'd0, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL req_vs_loss: state/pll_rst/loss got %b want 00110", {state_o, pll_rst, loss_cnt});
    end
    pll_locked = 1'b1;
    wait_state(2'd3, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL req_vs_loss_relock: state %0d want 3", state_o);
    end
  endtask

  task automatic test_loss_saturate();
    bit ok;
    exp_q.push_back(3); exp_q.push_back(3); exp_q.push_back(3);
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b0;
      wait_state(2'd0, 10, ok);
      checks++;
      if (!ok || loss_cnt !== 2'(exp_q[0])) begin
        errors++;
        $display("FAIL loss_sat_%0d: state %0d loss %0d want state 0 loss %0d",
                 i, state_o, loss_cnt, exp_q[0]);
      end
      void'(exp_q.pop_front());
      pll_locked = 1'b1;
      wait_state(2'd3, 60, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL loss_sat_relock_%0d: state %0d want 3", i, state_o);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    pll_locked = 1'b0;
    wait_state(2'd1, 30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL async_reach_wait: state %0d want 1", state_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, sys_reset, ready, state_o, retry_cnt, loss_cnt} !== 9'b1_1_0_00_00_00) begin
      errors++;
      $display("FAIL async_reset_wait: got %b want 110000000",
               {pll_rst, sys_reset, ready, state_o, retry_cnt, loss_cnt});
    end
    @(negedge refclk);
    rst_n = 1'b1;
    pll_locked = 1'b1;
    wait_state(2'd3, 60, ok);
    checks++;
    if (!ok || ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reach_run: state %0d ready %0d want 3/1", state_o, ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rst, sys_reset, ready, state_o, retry_cnt, loss_cnt} !== 9'b1_1_0_00_00_00) begin
      errors++;
      $display("FAIL async_reset_run: got %b want 110000000",
               {pll_rst, sys_reset, ready, state_o, retry_cnt, loss_cnt});
    end
    @(negedge refclk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_retry();
    test_stable_glitch();
    test_lock_loss();
    test_reset_req();
    test_loss_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
